// File: rtl/f_writeback_arbiter_pkg.sv
// f_writeback_arbiter_pkg: shared constants and types for the FP write-back port
package f_writeback_arbiter_pkg;
  localparam int N_FP_WB_REQ = 4;
  typedef enum logic [1:0] {FP_WB_ADD, FP_WB_MUL, FP_WB_DIV, FP_WB_LOAD} fp_wb_req_e;
  typedef logic [4:0] f_register_e;
  typedef logic [31:0] float_t;
endpackage

// File: rtl/f_writeback_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with one-hot grant and an internal rotating pointer
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, nxt, idx;
  // descending scan so the lowest offset from ptr is the last (winning) assignment
  always_comb begin
    grant = '0;
    nxt = ptr;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant = '0;
        grant[idx] = 1'b1;
        nxt = PW'((int'(ptr) + k + 1) % N);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (advance && |grant) ptr <= nxt;
endmodule

// File: rtl/f_writeback_arbiter.sv
// f_writeback_arbiter: round-robin FP register-file write-back with pending-write scoreboard
module f_writeback_arbiter
  import f_writeback_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_FP_WB_REQ,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic                    issue_valid_i,
  input  logic [ADDR_W-1:0]       issue_addr_i,
  input  logic                    flush_i,
  output logic                    rf_we_o,
  output logic [ADDR_W-1:0]       rf_waddr_o,
  output logic [DATA_W-1:0]       rf_wdata_o,
  output logic [31:0]             busy_o
);
  logic [N_REQ-1:0]  grant;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic [31:0]       busy_nxt;
  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk(clk_i),
    .rst_n(rst_n_i),
    .req(req_valid_i),
    .advance(|req_valid_i),
    .grant(grant)
  );
  assign req_ready_o = rst_n_i ? grant : '0;
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) begin
        win_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        win_data = req_data_i[i*DATA_W +: DATA_W];
      end
  end
  // issue set is applied last so it beats both a same-register clear and a flush
  always_comb begin
    busy_nxt = flush_i ? '0 : busy_o;
    if (rf_we_o) busy_nxt[rf_waddr_o] = 1'b0;
    if (issue_valid_i) busy_nxt[issue_addr_i] = 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      busy_o     <= '0;
    end else begin
      rf_we_o <= |req_ready_o;
      busy_o  <= busy_nxt;
      if (|req_ready_o) begin
        rf_waddr_o <= win_addr;
        rf_wdata_o <= win_data;
      end
    end
endmodule

// File: tb/tb_f_writeback_arbiter.sv
// tb_f_writeback_arbiter: scoreboard bench for the FP write-back arbiter
module tb_f_writeback_arbiter;
  localparam int N = 4, AW = 5, DW = 32;
  logic          clk = 1'b0, rst_n_i = 1'b0;
  logic [N-1:0]  req_valid_i = '0, req_ready_o;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic          issue_valid_i = 1'b0, flush_i = 1'b0, rf_we_o;
  logic [AW-1:0] issue_addr_i = '0, rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic [31:0]   busy_o;
  int tests = 0, fails = 0;
  logic [AW+DW-1:0] sb[$];
  int mptr = 0, mg;
  logic exp_we = 1'b0;
  logic [N-1:0] hs = '0, pend = '0, er;
  logic [N*AW-1:0] paddr = '0;
  logic [N*DW-1:0] pdata = '0;
  logic [AW+DW-1:0] ev;

  always #5 clk = ~clk;

  f_writeback_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .issue_valid_i(issue_valid_i), .issue_addr_i(issue_addr_i), .flush_i(flush_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .busy_o(busy_o)
  );

  function automatic int arb(input logic [N-1:0] v, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (v[j[1:0]]) return j;
    end
    return -1;
  endfunction

  // scoreboard: grants predicted from the bench's own pointer, writes popped one cycle later
  always @(negedge clk) begin
    if (!rst_n_i) begin
      mptr = 0;
      exp_we = 1'b0;
      sb.delete();
      pend = '0;
      hs = '0;
    end else begin
      tests++;
      if (rf_we_o !== exp_we) begin
        fails++;
        $display("FAIL sb_we: got %b want %b at %0t", rf_we_o, exp_we, $time);
      end
      if (rf_we_o === 1'b1 && exp_we && sb.size() > 0) begin
        ev = sb.pop_front();
        tests++;
        if ({rf_waddr_o, rf_wdata_o} !== ev) begin
          fails++;
          $display("FAIL sb_write: got %h/%h want %h/%h", rf_waddr_o, rf_wdata_o, ev[AW+DW-1:DW], ev[DW-1:0]);
        end
      end
      for (int i = 0; i < N; i++)
        if (pend[i]) begin
          tests++;
          if (!req_valid_i[i] || req_addr_i[i*AW +: AW] !== paddr[i*AW +: AW] || req_data_i[i*DW +: DW] !== pdata[i*DW +: DW]) begin
            fails++;
            $display("FAIL retract: requester %0d changed before ready", i);
          end
        end
      mg = arb(req_valid_i, mptr);
      er = '0;
      if (mg >= 0) er[mg[1:0]] = 1'b1;
      tests++;
      if (req_ready_o !== er) begin
        fails++;
        $display("FAIL sb_grant: got %b want %b at %0t", req_ready_o, er, $time);
      end
      exp_we = mg >= 0;
      if (mg >= 0) begin
        sb.push_back({req_addr_i[mg*AW +: AW], req_data_i[mg*DW +: DW]});
        mptr = (mg + 1) % N;
      end
      hs = req_valid_i & req_ready_o;
      pend = req_valid_i & ~req_ready_o;
      paddr = req_addr_i;
      pdata = req_data_i;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    req_valid_i = req_valid_i & ~hs;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid_i[i[1:0]] = 1'b1;
    req_addr_i[i*AW +: AW] = a;
    req_data_i[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    req_valid_i = '0;
    issue_valid_i = 1'b0;
    flush_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
  endtask

  task automatic drain();
    int c = 0;
    while (req_valid_i != '0 && c < 4 * N) begin
      cycle();
      c++;
    end
    tests++;
    if (req_valid_i != '0) begin
      fails++;
      $display("FAIL drain: valid %b still pending after %0d cycles", req_valid_i, c);
    end
    repeat (2) cycle();
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 32'hA000_0000 + i);
    @(negedge clk);
    tests++; if (req_ready_o !== 4'b0000) begin fails++; $display("FAIL rst_ready: got %b want 0000", req_ready_o); end
    tests++; if (rf_we_o !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", rf_we_o); end
    tests++; if (busy_o !== 32'h0) begin fails++; $display("FAIL rst_busy: got %h want 0", busy_o); end
    tests++; if ({rf_waddr_o, rf_wdata_o} !== '0) begin fails++; $display("FAIL rst_rf: got %h/%h want 0/0", rf_waddr_o, rf_wdata_o); end
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    @(negedge clk);
    tests++; if (req_ready_o !== 4'b0001) begin fails++; $display("FAIL rst_first_grant: got %b want 0001", req_ready_o); end
    drain();
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 5'd5, 32'h3F80_0000);
    @(negedge clk);
    tests++; if (req_ready_o !== 4'b0010) begin fails++; $display("FAIL single_ready: got %b want 0010", req_ready_o); end
    cycle();
    @(negedge clk);
    tests++; if (rf_we_o !== 1'b1) begin fails++; $display("FAIL single_we: got %b want 1", rf_we_o); end
    tests++; if (rf_waddr_o !== 5'd5) begin fails++; $display("FAIL single_addr: got %0d want 5", rf_waddr_o); end
    tests++; if (rf_wdata_o !== 32'h3F80_0000) begin fails++; $display("FAIL single_data: got %h want 3f800000", rf_wdata_o); end
    cycle();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] w;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, AW'(8 + i), 32'h100 + i);
    for (int c = 0; c < 8; c++) begin
      w = 4'b0001 << (c % N);
      @(negedge clk);
      tests++; if (req_ready_o !== w) begin fails++; $display("FAIL rr_grant%0d: got %b want %b", c, req_ready_o, w); end
      if (c >= 1) begin
        tests++; if (rf_we_o !== 1'b1) begin fails++; $display("FAIL rr_we%0d: got %b want 1", c, rf_we_o); end
      end
      cycle();
      set_req(c % N, AW'(8 + c % N), 32'h200 + c);
    end
    @(negedge clk);
    tests++; if (rf_we_o !== 1'b1) begin fails++; $display("FAIL rr_we8: got %b want 1", rf_we_o); end
    drain();
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_valid_i = 1'b1;
    issue_addr_i = 5'd7;
    @(negedge clk);
    tests++; if (busy_o !== 32'h0) begin fails++; $display("FAIL sbd_comb: got %h want 0", busy_o); end
    cycle();
    issue_valid_i = 1'b0;
    @(negedge clk);
    tests++; if (busy_o !== 32'h80) begin fails++; $display("FAIL sbd_set: got %h want 80", busy_o); end
    cycle();
    set_req(2, 5'd7, 32'h4049_0FDB);
    @(negedge clk);
    tests++; if (req_ready_o !== 4'b0100) begin fails++; $display("FAIL sbd_ready: got %b want 0100", req_ready_o); end
    cycle();
    @(negedge clk);
    tests++; if (busy_o !== 32'h80) begin fails++; $display("FAIL sbd_hold: got %h want 80", busy_o); end
    cycle();
    @(negedge clk);
    tests++; if (busy_o !== 32'h0) begin fails++; $display("FAIL sbd_clear: got %h want 0", busy_o); end
  endtask

  task automatic test_collision();
    do_reset();
    issue_valid_i = 1'b1;
    issue_addr_i = 5'd9;
    set_req(0, 5'd9, 32'h1111_1111);
    cycle();
    @(negedge clk);
    tests++; if (rf_we_o !== 1'b1 || busy_o !== 32'h200) begin fails++; $display("FAIL col_setup: got we=%b busy=%h want 1/200", rf_we_o, busy_o); end
    cycle();
    issue_valid_i = 1'b0;
    @(negedge clk);
    tests++; if (busy_o !== 32'h200) begin fails++; $display("FAIL col_same: got %h want 200", busy_o); end
    set_req(0, 5'd9, 32'h2222_2222);
    cycle();
    issue_valid_i = 1'b1;
    issue_addr_i = 5'd10;
    @(negedge clk);
    tests++; if (rf_we_o !== 1'b1) begin fails++; $display("FAIL col_we: got %b want 1", rf_we_o); end
    cycle();
    issue_valid_i = 1'b0;
    @(negedge clk);
    tests++; if (busy_o !== 32'h400) begin fails++; $display("FAIL col_diff: got %h want 400", busy_o); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int r = 4; r < 8; r++) begin
      issue_valid_i = 1'b1;
      issue_addr_i = AW'(r);
      cycle();
    end
    issue_valid_i = 1'b0;
    set_req(3, 5'd20, 32'hDEAD_BEEF);
    @(negedge clk);
    tests++; if (busy_o !== 32'hF0) begin fails++; $display("FAIL flush_pre: got %h want f0", busy_o); end
    cycle();
    flush_i = 1'b1;
    issue_valid_i = 1'b1;
    issue_addr_i = 5'd2;
    set_req(0, 5'd3, 32'hCAFE_F00D);
    @(negedge clk);
    tests++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd20) begin fails++; $display("FAIL flush_write: got we=%b addr=%0d want 1/20", rf_we_o, rf_waddr_o); end
    tests++; if (req_ready_o !== 4'b0001) begin fails++; $display("FAIL flush_arb: got %b want 0001", req_ready_o); end
    cycle();
    flush_i = 1'b0;
    issue_valid_i = 1'b0;
    @(negedge clk);
    tests++; if (busy_o !== 32'h4) begin fails++; $display("FAIL flush_busy: got %h want 4", busy_o); end
    cycle();
  endtask

  task automatic test_same_reg();
    do_reset();
    issue_valid_i = 1'b1;
    issue_addr_i = 5'd0;
    set_req(0, 5'd0, 32'hAAAA_0000);
    set_req(1, 5'd0, 32'hBBBB_0000);
    @(negedge clk);
    tests++; if (req_ready_o !== 4'b0001) begin fails++; $display("FAIL same_g0: got %b want 0001", req_ready_o); end
    cycle();
    issue_valid_i = 1'b0;
    @(negedge clk);
    tests++; if (req_ready_o !== 4'b0010) begin fails++; $display("FAIL same_g1: got %b want 0010", req_ready_o); end
    tests++; if (busy_o !== 32'h1) begin fails++; $display("FAIL same_f0busy: got %h want 1", busy_o); end
    cycle();
    @(negedge clk);
    tests++; if (rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'hBBBB_0000) begin fails++; $display("FAIL same_last: got %0d/%h want 0/bbbb0000", rf_waddr_o, rf_wdata_o); end
    tests++; if (busy_o !== 32'h0) begin fails++; $display("FAIL same_f0clr: got %h want 0", busy_o); end
    cycle();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    set_req(2, 5'd17, 32'h1234_5678);
    cycle();
    rst_n_i = 1'b0;
    req_valid_i = '1;
    @(negedge clk);
    tests++; if (rf_we_o !== 1'b0 || req_ready_o !== 4'b0000) begin fails++; $display("FAIL inflight_rst: got we=%b ready=%b want 0/0000", rf_we_o, req_ready_o); end
    cycle();
    req_valid_i = '0;
    rst_n_i = 1'b1;
    @(negedge clk);
    tests++; if (rf_we_o !== 1'b0) begin fails++; $display("FAIL inflight_nowrite: got %b want 0", rf_we_o); end
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_scoreboard();
    test_collision();
    test_flush();
    test_same_reg();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
